// File: rtl/onehot_decoder_buffered.sv
// Binary-to-one-hot decoder behind a 2-entry FIFO with valid/ready on both sides.
// Codes are decoded on push, so the FIFO stores one-hot words and dout is a register.
module onehot_decoder_buffered #(
    parameter int unsigned CODE_W = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [CODE_W-1:0]        din_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [(1<<CODE_W)-1:0]   dout_o,
    output logic [7:0]               count_o
);

    localparam int unsigned OutW = 1 << CODE_W;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            state_q;
    logic [OutW-1:0]   head_q;
    logic [OutW-1:0]   tail_q;
    logic [7:0]        count_q;
    logic [OutW-1:0]   dec_word;
    logic              push;
    logic              pop;

    // Readiness depends only on registered occupancy: no pass-through when full.
    assign in_ready_o  = en_i & (state_q != StTwo) & ~rst_i;
    assign out_valid_o = (state_q != StEmpty);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign dec_word    = OutW'(1) << din_i;
    assign dout_o      = head_q;
    assign count_o     = count_q;

    // head_q is kept at zero whenever the FIFO is empty so dout reads all zeros.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                count_q <= count_q + 8'd1;
            end
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        head_q  <= dec_word;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        tail_q  <= dec_word;
                        state_q <= StTwo;
                    end else if (push && pop) begin
                        head_q <= dec_word;
                    end else if (pop) begin
                        head_q  <= '0;
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        tail_q  <= '0;
                        state_q <= StOne;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    head_q  <= '0;
                    tail_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_decoder_buffered.sv
// Directed bench for onehot_decoder_buffered: a queue model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_onehot_decoder_buffered;

    logic       clk;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] din;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] dout;
    logic [7:0] count;

    int vectors;
    int miscompares;

    logic [3:0] mq[$];
    int         mcnt;
    bit         armed;

    onehot_decoder_buffered #(.CODE_W(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .din_i       (din),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .dout_o      (dout),
        .count_o     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Queue model: FIFO of decoded words, pop before push, push only while below two entries.
    always @(posedge clk) begin
        bit mpush;
        bit mpop;
        if (rst) begin
            mq.delete();
            mcnt  = 0;
            armed = 1'b1;
        end else if (armed) begin
            mpop  = (mq.size() > 0) && out_ready;
            mpush = in_valid && en && (mq.size() < 2);
            if (mpop) begin
                void'(mq.pop_front());
                mcnt = (mcnt + 1) % 256;
            end
            if (mpush) mq.push_back(4'b0001 << din);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("in_ready", {7'd0, in_ready}, {7'd0, (en && !rst && mq.size() < 2)});
            check("out_valid", {7'd0, out_valid}, {7'd0, (mq.size() > 0)});
            check("dout", {4'd0, dout}, {4'd0, (mq.size() > 0) ? mq[0] : 4'b0000});
            check("count", count, 8'(mcnt));
        end
    end

    task automatic drive(input logic r, input logic iv, input logic [1:0] d, input logic e,
                         input logic ordy);
        rst       = r;
        in_valid  = iv;
        din       = d;
        en        = e;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        armed       = 1'b0;
        mcnt        = 0;

        // Reset held two cycles with a valid offer present.
        drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
        tick;
        drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
        check("lit_rst_in_ready", {7'd0, in_ready}, 8'd0);
        tick;
        drive(1'b0, 1'b0, 2'bxx, 1'b1, 1'b0);
        check("lit_post_rst_ready", {7'd0, in_ready}, 8'd1);
        check("lit_post_rst_valid", {7'd0, out_valid}, 8'd0);
        check("lit_post_rst_dout", {4'd0, dout}, 8'd0);
        check("lit_post_rst_count", count, 8'd0);

        // Single decode of 2'b10.
        drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
        tick;
        drive(1'b0, 1'b0, 2'bxx, 1'b1, 1'b1);
        check("lit_single_valid", {7'd0, out_valid}, 8'd1);
        check("lit_single_dout", {4'd0, dout}, 8'h04);
        tick;
        check("lit_single_empty", {7'd0, out_valid}, 8'd0);
        check("lit_single_zero", {4'd0, dout}, 8'd0);
        check("lit_single_count", count, 8'd1);

        // Streaming 00..11 with out_ready high.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'(i), 1'b1, 1'b1);
            tick;
            check("lit_stream_dout", {4'd0, dout}, 8'(1 << i));
        end
        drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        tick;
        check("lit_stream_count", count, 8'd5);

        // Backpressure: 11 and 01 fill the FIFO, 10 waits.
        drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
        tick;
        drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
        tick;
        drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
        check("lit_bp_full_ready", {7'd0, in_ready}, 8'd0);
        tick;
        check("lit_bp_hold_dout", {4'd0, dout}, 8'h08);
        tick;
        drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
        tick;
        check("lit_bp_dout2", {4'd0, dout}, 8'h02);
        check("lit_bp_ready_back", {7'd0, in_ready}, 8'd1);
        tick;
        drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        check("lit_bp_dout3", {4'd0, dout}, 8'h04);
        tick;
        check("lit_bp_count", count, 8'd8);

        // Simultaneous push/pop in ONE, then en gating while draining.
        drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
        tick;
        drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
        tick;
        check("lit_pp_valid", {7'd0, out_valid}, 8'd1);
        check("lit_pp_dout", {4'd0, dout}, 8'h08);
        drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
        tick;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b1);
            check("lit_en_gate_ready", {7'd0, in_ready}, 8'd0);
            tick;
        end
        check("lit_en_drained", {7'd0, out_valid}, 8'd0);
        check("lit_en_count", count, 8'd11);
        drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
        tick;
        drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        check("lit_en_resume", {4'd0, dout}, 8'h04);
        tick;

        // Fill to TWO, then reset drops both entries without popping.
        drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
        tick;
        drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
        tick;
        drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        check("lit_full_before_rst", {7'd0, in_ready}, 8'd0);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        tick;
        drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        check("lit_midrst_dout", {4'd0, dout}, 8'd0);
        check("lit_midrst_valid", {7'd0, out_valid}, 8'd0);
        check("lit_midrst_count", count, 8'd0);

        // 257 pops wrap the counter to 1.
        for (int i = 0; i < 257; i++) begin
            drive(1'b0, 1'b1, 2'(i % 4), 1'b1, 1'b1);
            tick;
        end
        drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        tick;
        check("lit_wrap_count", count, 8'd1);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
